// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
//
// Direct-mapped, read-only instruction cache between the CPU fetch stage and
// instruction_memory.
//
// On a hit the requested 32-bit word is returned in the same cycle, with no
// stall. On a miss the cache stalls the CPU through busywait, reads the whole
// 16-byte block from instruction_memory, installs it, and then serves the word.
//
// Parameters:
//   NUM_BLOCKS   number of cache lines (power of two, >= 2)
//
// Ports:
//   clock          system clock, rising edge active
//   reset_n        asynchronous active-low reset
//   read           CPU fetch request
//   address        CPU byte PC; bits [1:0] are ignored
//   instruction    selected word of the indexed line; valid when read=1 and
//                  busywait=0
//   busywait       CPU stall
//   mem_read       block read request to instruction_memory
//   mem_address    block address of the miss (PC[31:4])
//   mem_readinst   block data from memory; word k = bits [32k+31:32k]
//   mem_busywait   instruction_memory busy
//
// Optional feature (macro ICACHE_STATS_EN):
//   When defined, adds the outputs hit_count[31:0] and miss_count[31:0]. Both
//   are saturating event counters and are cleared by reset.
// -----------------------------------------------------------------------------
module instruction_cache #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         read,
  input  logic [31:0]  address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_e;

  // Line storage. Tags and data have no reset; the valid bits guard them.
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];

  state_e                state_q;
  logic                  first_q;      // set during the first MEM_READ cycle
  logic [27:0]           miss_addr_q;  // block address captured on the miss
  logic                  mem_read_q;

`ifdef ICACHE_STATS_EN
  logic [31:0]           hit_count_q;
  logic [31:0]           miss_count_q;
`endif

  // Address decode for the current fetch.
  logic [INDEX_W-1:0]    index_s;
  logic [TAG_W-1:0]      tag_s;
  logic [1:0]            word_s;
  logic [127:0]          line_s;
  logic                  hit_s;
  logic                  miss_s;

  // Fill target, taken from the captured miss address and not from the live PC.
  logic [INDEX_W-1:0]    fill_idx_s;
  logic [TAG_W-1:0]      fill_tag_s;

  // The byte offset within a word plays no part in the lookup.
  logic                  unused_addr_s;

  assign unused_addr_s = ^address[1:0];

  assign index_s    = address[4 +: INDEX_W];
  assign tag_s      = address[31 -: TAG_W];
  assign word_s     = address[3:2];
  assign line_s     = data_q[index_s];
  assign hit_s      = read & valid_q[index_s] & (tag_q[index_s] == tag_s);
  assign miss_s     = read & ~hit_s;

  assign fill_idx_s = miss_addr_q[INDEX_W-1:0];
  assign fill_tag_s = miss_addr_q[27 -: TAG_W];

  assign mem_read    = mem_read_q;
  assign mem_address = miss_addr_q;

  // Word select from the indexed line, driven in every state.
  always_comb begin
    instruction = 32'h0000_0000;
    case (word_s)
      2'd0:    instruction = line_s[31:0];
      2'd1:    instruction = line_s[63:32];
      2'd2:    instruction = line_s[95:64];
      2'd3:    instruction = line_s[127:96];
      default: instruction = 32'h0000_0000;
    endcase
  end

  // Stall: in IDLE it follows the lookup, so a hit never stalls and the
  // re-evaluated hit releases the CPU in the same cycle the fill returns to IDLE.
  // Reset forces it low at once, regardless of the request.
  always_comb begin
    busywait = 1'b0;
    if (!reset_n) begin
      busywait = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:     busywait = miss_s;
        S_MEM_READ: busywait = 1'b1;
        S_UPDATE:   busywait = 1'b1;
        default:    busywait = 1'b0;
      endcase
    end
  end

  // Miss-handling FSM. It also maintains the valid bits, the memory request
  // outputs and the optional statistics counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      first_q      <= 1'b0;
      miss_addr_q  <= 28'h000_0000;
      mem_read_q   <= 1'b0;
      valid_q      <= {NUM_BLOCKS{1'b0}};
`ifdef ICACHE_STATS_EN
      hit_count_q  <= 32'h0000_0000;
      miss_count_q <= 32'h0000_0000;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_s) begin
            miss_addr_q <= address[31:4];
            mem_read_q  <= 1'b1;
            first_q     <= 1'b1;
            state_q     <= S_MEM_READ;
`ifdef ICACHE_STATS_EN
            if (miss_count_q != 32'hFFFF_FFFF) begin
              miss_count_q <= miss_count_q + 32'd1;
            end
`endif
          end
`ifdef ICACHE_STATS_EN
          if (hit_s && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_q <= hit_count_q + 32'd1;
          end
`endif
        end
        S_MEM_READ: begin
          // The memory raises its busywait only after seeing the request, so
          // its level is meaningless on the first edge after entry.
          if (first_q) begin
            first_q <= 1'b0;
          end else if (!mem_busywait) begin
            mem_read_q <= 1'b0;
            state_q    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid_q[fill_idx_s] <= 1'b1;
          state_q             <= S_IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          first_q    <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Line fill: a conflicting line is overwritten unconditionally.
  always_ff @(posedge clock) begin
    if (state_q == S_UPDATE) begin
      data_q[fill_idx_s] <= mem_readinst;
      tag_q[fill_idx_s]  <= fill_tag_s;
    end
  end

`ifdef ICACHE_STATS_EN
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
